pipe_skid_stage: RTL and testbench
==================================

# pipe_skid_stage

Parametrised, handshaked pipeline stage register: the next-generation replacement for the fixed-field inter-stage registers between IF/ID/EX/MEM/WB. It carries an opaque `WIDTH`-bit payload under a valid/ready handshake, with a two-entry skid buffer for full throughput with a registered `in_ready`. It also provides synchronous flush, occupancy reporting and a saturating backpressure counter. One instance sits between each pair of adjacent pipeline stages.

## Interface
Parameters:
- `WIDTH`, 64: payload bits per entry.
- `RESET_VALUE`, `WIDTH'h0`: payload value loaded into both entries on reset.
- `CNT_W`, 16: width of the backpressure counter.

Ports:
- `clk` in 1: single clock; every register updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `flush` in 1: discard all held entries.
- `in_valid` in 1: upstream presents a payload.
- `in_ready` out 1: stage can accept; registered.
- `in_data` in `WIDTH`: upstream payload.
- `out_valid` out 1: main entry holds a valid payload.
- `out_ready` in 1: downstream consumes this cycle.
- `out_data` out `WIDTH`: main entry payload.
- `occupancy` out 2: number of valid entries, 0 to 2.
- `stall_cycles` out `CNT_W`: saturating count of backpressured cycles.
- `cnt_clr` in 1: clear `stall_cycles`.
- `debug_in_instr` in 32: instruction word for trace. Present only with `PIPE_DEBUG_INSTR_EN`.
- `debug_out_instr` out 32: instruction word for trace. Present only with `PIPE_DEBUG_INSTR_EN`.

## Operation
- Accept occurs when `in_valid && in_ready`. Pop occurs when `out_valid && out_ready`.
- The stage holds two entries: main (drives `out_*`) and skid.
- State machine with three states:
  - EMPTY: occupancy 0.
  - ONE: main valid.
  - FULL: main and skid valid.
- `in_ready` = (next state != FULL). It is a flop, not a combinational function of `out_ready`.
- Transitions:
  - EMPTY + accept -> ONE; main <= `in_data`.
  - ONE + accept, no pop -> FULL; skid <= `in_data`.
  - ONE + pop, no accept -> EMPTY.
  - ONE + accept + pop -> ONE; main <= `in_data`.
  - FULL + pop -> ONE; main <= skid.
  - No accept is possible in FULL, since `in_ready` is 0.
  - Any other combination holds state and data.
- Payload order is strictly FIFO. No entry is dropped or duplicated outside flush.
- `flush` (priority below `rst`, above everything else):
  - Next state EMPTY; `in_ready` = 1 next cycle.
  - A payload accepted in the flush cycle is discarded.
  - Payload registers hold their values.
  - `out_valid` is 0 the next cycle.
- `stall_cycles` increments each cycle `out_valid && !out_ready`, saturating at all-ones.
  - `cnt_clr` zeroes it; `cnt_clr` takes priority over the increment in the same cycle.
  - `flush` does not affect the counter.
- Reset values:
  - State EMPTY, `out_valid` 0, `in_ready` 1, `occupancy` 0.
  - Both payload entries = `RESET_VALUE`, so `out_data` = `RESET_VALUE`.
  - `stall_cycles` 0.
  - `debug_out_instr` 32'h13.
- `rst` mid-transfer abandons both entries with no partial state kept.

## Timing
- Latency: payload accepted in cycle N appears on `out_data` with `out_valid` = 1 in cycle N+1.
- Throughput: one payload per cycle whenever `out_ready` is held high.
- Backpressure: after `out_ready` drops, at most one further payload is accepted (into skid). `in_ready` falls the cycle after skid fills.
- Recovery: from FULL, the first pop raises `in_ready` the following cycle.
- `occupancy` and `stall_cycles` are registered and reflect the state after the current edge.

## Configuration
- Macro `PIPE_DEBUG_INSTR_EN`.
- Defined:
  - Each entry carries an extra 32-bit instruction word, moved in lockstep with the payload.
  - Reset sets both debug words to 32'h13 (NOP).
  - Flush sets both debug words to 32'h13.
  - `debug_out_instr` follows the main entry.
- Undefined: the debug ports and registers are absent; payload behaviour is identical.

## Structure
- Shared package `common.vh` holds:
  - State encodings `PIPE_ST_EMPTY` = 2'd0, `PIPE_ST_ONE` = 2'd1, `PIPE_ST_FULL` = 2'd2.
  - `PIPE_NOP_INSTR` = 32'h13.
  - `ARCH_WIDTH` and `DATA_WIDTH`, used by instantiating stages to size `WIDTH`.
- One sub-module, `pipe_sat_counter`: parametrised `CNT_W` saturating counter with `inc` and `clr` inputs, used for `stall_cycles`.
- Callers pack and unpack stage fields into the payload; this block never interprets payload bits.

## Test plan
1. Reset: assert `rst` 2 cycles with `RESET_VALUE` = 64'hDEAD.
   - Expect `out_valid` 0, `in_ready` 1, `occupancy` 0, `out_data` 64'hDEAD, `stall_cycles` 0, `debug_out_instr` 32'h13.
2. Streaming: `out_ready` = 1, send 1, 2, 3, 4 on consecutive cycles.
   - Expect `out_data` 1, 2, 3, 4 in cycles N+1 to N+4.
   - `in_ready` stays 1 and `occupancy` never exceeds 1.
3. Backpressure: `out_ready` = 0, send 10, 11, 12.
   - 10 and 11 are accepted; `in_ready` = 0 after 11; `occupancy` = 2; 12 is held by upstream.
   - Then `out_ready` = 1: expect 10, 11, 12 in order.
   - `stall_cycles` equals the number of cycles with `out_valid` high and `out_ready` low.
4. Flush in FULL, with `in_valid` = 1 carrying 7.
   - Next cycle `out_valid` 0, `occupancy` 0, `in_ready` 1; 7 never appears.
   - With `PIPE_DEBUG_INSTR_EN`, `debug_out_instr` reads 32'h13.
5. Counter saturation with `CNT_W` = 4: stall 20 cycles.
   - Expect `stall_cycles` = 4'hF.
   - `cnt_clr` together with a stall gives 0.
6. Reset mid-operation: `rst` in FULL while `in_valid` is high.
   - Next cycle all outputs equal their reset values; the next accepted payload emerges after 1 cycle.

Source files
------------

// File: rtl/pipe_skid_stage_pkg.sv
// Shared definitions for the handshaked pipeline stage register: state
// encodings, the trace NOP word and the datapath widths used to size WIDTH.
package pipe_skid_stage_pkg;

  typedef enum logic [1:0] {
    PIPE_ST_EMPTY = 2'd0,
    PIPE_ST_ONE   = 2'd1,
    PIPE_ST_FULL  = 2'd2
  } pipeState_e;

  localparam logic [31:0] PIPE_NOP_INSTR = 32'h0000_0013;
  localparam int ARCH_WIDTH = 32;
  localparam int DATA_WIDTH = 64;

  function automatic logic [1:0] stateToOccupancy(input pipeState_e st);
    logic [1:0] occ;
    occ = 2'd0;
    case (st)
      PIPE_ST_ONE:  occ = 2'd1;
      PIPE_ST_FULL: occ = 2'd2;
      default:      occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/pipe_skid_stage_sat_counter.sv
// Saturating event counter: counts up on inc, sticks at all-ones, clr wins.
module pipe_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_skid_stage.sv
// Two-entry skid-buffered pipeline stage with registered in_ready, flush,
// occupancy and stall counter. Define PIPE_DEBUG_INSTR_EN to add trace words.
module pipe_skid_stage
  import pipe_skid_stage_pkg::*;
#(
  parameter int               WIDTH       = 64,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int               CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cycles,
`ifdef PIPE_DEBUG_INSTR_EN
  input  logic [31:0]      debug_in_instr,
  output logic [31:0]      debug_out_instr,
`endif
  input  logic             cnt_clr
);

  pipeState_e       state_q, state_d;
  logic [WIDTH-1:0] mainData_q, mainData_d;
  logic [WIDTH-1:0] skidData_q, skidData_d;
  logic             inReady_q;
  logic             accept;
  logic             pop;

  assign accept = in_valid && inReady_q;
  assign pop    = (state_q != PIPE_ST_EMPTY) && out_ready;

  // Next-state and entry movement; flush drops state but leaves payloads.
  always_comb begin
    state_d    = state_q;
    mainData_d = mainData_q;
    skidData_d = skidData_q;
    case (state_q)
      PIPE_ST_EMPTY: begin
        if (accept) begin
          state_d    = PIPE_ST_ONE;
          mainData_d = in_data;
        end
      end
      PIPE_ST_ONE: begin
        if (accept && pop) begin
          mainData_d = in_data;
        end else if (accept) begin
          state_d    = PIPE_ST_FULL;
          skidData_d = in_data;
        end else if (pop) begin
          state_d = PIPE_ST_EMPTY;
        end
      end
      PIPE_ST_FULL: begin
        if (pop) begin
          state_d    = PIPE_ST_ONE;
          mainData_d = skidData_q;
        end
      end
      default: state_d = PIPE_ST_EMPTY;
    endcase
    if (flush) begin
      state_d    = PIPE_ST_EMPTY;
      mainData_d = mainData_q;
      skidData_d = skidData_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= PIPE_ST_EMPTY;
      mainData_q <= RESET_VALUE;
      skidData_q <= RESET_VALUE;
      inReady_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      mainData_q <= mainData_d;
      skidData_q <= skidData_d;
      inReady_q  <= (state_d != PIPE_ST_FULL);
    end
  end

`ifdef PIPE_DEBUG_INSTR_EN
  logic [31:0] mainInstr_q, mainInstr_d;
  logic [31:0] skidInstr_q, skidInstr_d;

  // Trace words shadow the payload moves; flush scrubs them back to NOP.
  always_comb begin
    mainInstr_d = mainInstr_q;
    skidInstr_d = skidInstr_q;
    if (flush) begin
      mainInstr_d = PIPE_NOP_INSTR;
      skidInstr_d = PIPE_NOP_INSTR;
    end else begin
      case (state_q)
        PIPE_ST_EMPTY: if (accept) mainInstr_d = debug_in_instr;
        PIPE_ST_ONE: begin
          if (accept && pop) mainInstr_d = debug_in_instr;
          else if (accept)   skidInstr_d = debug_in_instr;
        end
        PIPE_ST_FULL: if (pop) mainInstr_d = skidInstr_q;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mainInstr_q <= PIPE_NOP_INSTR;
      skidInstr_q <= PIPE_NOP_INSTR;
    end else begin
      mainInstr_q <= mainInstr_d;
      skidInstr_q <= skidInstr_d;
    end
  end

  assign debug_out_instr = mainInstr_q;
`endif

  pipe_sat_counter #(
    .CNT_W(CNT_W)
  ) u_stallCounter (
    .clk  (clk),
    .rst  (rst),
    .inc  (out_valid && !out_ready),
    .clr  (cnt_clr),
    .count(stall_cycles)
  );

  assign in_ready  = inReady_q;
  assign out_valid = (state_q != PIPE_ST_EMPTY);
  assign out_data  = mainData_q;
  assign occupancy = stateToOccupancy(state_q);

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed self-checking bench for pipe_skid_stage (RESET_VALUE 'hDEAD, CNT_W 4).
module tb_pipe_skid_stage;

  localparam int WIDTH = 64;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       occupancy;
  logic [CNT_W-1:0] stall_cycles;
  logic             cnt_clr;
`ifdef PIPE_DEBUG_INSTR_EN
  logic [31:0]      debug_in_instr;
  logic [31:0]      debug_out_instr;
`endif

  int checkCount = 0;
  int errorCount = 0;

  always #5 clk = ~clk;

  pipe_skid_stage #(
    .WIDTH(WIDTH),
    .RESET_VALUE(64'hDEAD),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .occupancy(occupancy),
    .stall_cycles(stall_cycles),
`ifdef PIPE_DEBUG_INSTR_EN
    .debug_in_instr(debug_in_instr),
    .debug_out_instr(debug_out_instr),
`endif
    .cnt_clr(cnt_clr)
  );

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [63:0] d, input logic rdy);
    in_valid  = v;
    in_data   = d;
    out_ready = rdy;
`ifdef PIPE_DEBUG_INSTR_EN
    debug_in_instr = 32'h1000 + d[31:0];
`endif
  endtask

  task automatic checkState(input string tag, input logic v, input logic [63:0] d,
                            input logic rdy, input logic [1:0] occ);
    checkOutput({tag, ".out_valid"}, {63'd0, out_valid}, {63'd0, v});
    checkOutput({tag, ".out_data"}, out_data, d);
    checkOutput({tag, ".in_ready"}, {63'd0, in_ready}, {63'd0, rdy});
    checkOutput({tag, ".occupancy"}, {62'd0, occupancy}, {62'd0, occ});
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; cnt_clr = 1'b0;
    applyStimulus(1'b0, 64'd0, 1'b0);

    // Reset
    tick(); tick();
    rst = 1'b0;
    checkState("reset", 1'b0, 64'hDEAD, 1'b1, 2'd0);
    checkOutput("reset.stall", {60'd0, stall_cycles}, 64'd0);
`ifdef PIPE_DEBUG_INSTR_EN
    checkOutput("reset.dbg", {32'd0, debug_out_instr}, 64'h13);
`endif

    // Streaming at full throughput
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b1, 64'(i), 1'b1);
      tick();
      checkState($sformatf("stream%0d", i), 1'b1, 64'(i), 1'b1, 2'd1);
`ifdef PIPE_DEBUG_INSTR_EN
      checkOutput($sformatf("stream%0d.dbg", i), {32'd0, debug_out_instr}, 64'h1000 + 64'(i));
`endif
    end
    applyStimulus(1'b0, 64'd0, 1'b1);
    tick();
    checkState("streamDrain", 1'b0, 64'd4, 1'b1, 2'd0);
    checkOutput("streamStall", {60'd0, stall_cycles}, 64'd0);

    // Backpressure into the skid entry
    applyStimulus(1'b1, 64'd10, 1'b0);
    tick();
    checkState("bp10", 1'b1, 64'd10, 1'b1, 2'd1);
    applyStimulus(1'b1, 64'd11, 1'b0);
    tick();
    checkState("bp11", 1'b1, 64'd10, 1'b0, 2'd2);
    checkOutput("bp11.stall", {60'd0, stall_cycles}, 64'd1);
    applyStimulus(1'b1, 64'd12, 1'b0);
    tick();
    checkState("bpHold", 1'b1, 64'd10, 1'b0, 2'd2);
    checkOutput("bpHold.stall", {60'd0, stall_cycles}, 64'd2);
    applyStimulus(1'b1, 64'd12, 1'b1);
    tick();
    checkState("bpPop11", 1'b1, 64'd11, 1'b1, 2'd1);
    tick();
    checkState("bpPop12", 1'b1, 64'd12, 1'b1, 2'd1);
    applyStimulus(1'b0, 64'd0, 1'b1);
    tick();
    checkState("bpDrain", 1'b0, 64'd12, 1'b1, 2'd0);
    checkOutput("bpDrain.stall", {60'd0, stall_cycles}, 64'd2);

    // Flush while full, offering 7
    applyStimulus(1'b1, 64'd20, 1'b0);
    tick();
    applyStimulus(1'b1, 64'd21, 1'b0);
    tick();
    checkState("preFlush", 1'b1, 64'd20, 1'b0, 2'd2);
    applyStimulus(1'b1, 64'd7, 1'b0);
    flush = 1'b1;
    tick();
    checkState("flushFull", 1'b0, 64'd20, 1'b1, 2'd0);
    checkOutput("flushFull.stall", {60'd0, stall_cycles}, 64'd4);
`ifdef PIPE_DEBUG_INSTR_EN
    checkOutput("flushFull.dbg", {32'd0, debug_out_instr}, 64'h13);
`endif
    // Flush while empty drops the payload accepted that cycle
    tick();
    checkState("flushEmpty", 1'b0, 64'd20, 1'b1, 2'd0);
    flush = 1'b0;
    applyStimulus(1'b0, 64'd0, 1'b1);
    tick();
    checkState("postFlush", 1'b0, 64'd20, 1'b1, 2'd0);

    // Counter clear and saturation
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    checkOutput("cntClr", {60'd0, stall_cycles}, 64'd0);
    applyStimulus(1'b1, 64'd30, 1'b0);
    tick();
    applyStimulus(1'b0, 64'd0, 1'b0);
    for (int i = 0; i < 20; i++) tick();
    checkOutput("cntSat", {60'd0, stall_cycles}, 64'hF);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    checkOutput("cntClrWins", {60'd0, stall_cycles}, 64'd0);
    tick();
    checkOutput("cntResume", {60'd0, stall_cycles}, 64'd1);

    // Reset in FULL with a pending input
    applyStimulus(1'b1, 64'd31, 1'b0);
    tick();
    checkState("preRst", 1'b1, 64'd30, 1'b0, 2'd2);
    applyStimulus(1'b1, 64'd32, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkState("midRst", 1'b0, 64'hDEAD, 1'b1, 2'd0);
    checkOutput("midRst.stall", {60'd0, stall_cycles}, 64'd0);
`ifdef PIPE_DEBUG_INSTR_EN
    checkOutput("midRst.dbg", {32'd0, debug_out_instr}, 64'h13);
`endif
    applyStimulus(1'b1, 64'd40, 1'b1);
    tick();
    checkState("postRst", 1'b1, 64'd40, 1'b1, 2'd1);
    applyStimulus(1'b0, 64'd0, 1'b1);
    tick();
    checkState("postRstDrain", 1'b0, 64'd40, 1'b1, 2'd0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
